// File: rtl/seq_detect_n.sv
// Serial pattern detector with programmable pattern, optional overlapping matches
// and a saturating match counter; fill (valid history bits) is the FSM state.
module seq_detect_n #(
    parameter int                PAT_W    = 4,
    parameter int                CNT_W    = 8,
    parameter logic [PAT_W-1:0]  PAT_INIT = PAT_W'(4'b1011)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         din,
    input  logic                         overlap,
    input  logic                         pat_load,
    input  logic [PAT_W-1:0]             pat_in,
    input  logic                         clr_cnt,
    output logic                         match,
    output logic [CNT_W-1:0]             match_cnt,
    output logic                         cnt_sat,
    output logic [$clog2(PAT_W+1)-1:0]   fill
);

    localparam int                FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [PAT_W-1:0]  pat_q,   pat_d;
    logic [PAT_W-1:0]  hist_q,  hist_d;
    logic [FILL_W-1:0] fill_q,  fill_d;
    logic              match_q, match_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    logic [PAT_W-1:0]  hist_sh;
    logic [FILL_W-1:0] fill_sh;
    logic              hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Post-shift view of the history; a match is judged on this, not on the old state.
    assign hist_sh = {hist_q[PAT_W-2:0], din};
    assign fill_sh = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
    assign hit     = en && !pat_load && (fill_sh == FILL_FULL) && (hist_sh == pat_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q   <= PAT_INIT;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        if (pat_load) begin
            pat_d  = pat_in;
            hist_d = '0;
            fill_d = '0;
        end else if (en) begin
            hist_d = hist_sh;
            // Non-overlapping mode restarts the fill so the next match needs fresh bits.
            fill_d = (hit && !overlap) ? '0 : fill_sh;
        end
    end

    always_comb begin
        match_d = hit;
        cnt_d   = clr_cnt ? '0 : cnt_q;
        if (hit) begin
            cnt_d = sat_inc(cnt_d);
        end
    end

    assign match     = match_q;
    assign match_cnt = cnt_q;
    assign cnt_sat   = (cnt_q == CNT_MAX);
    assign fill      = fill_q;

endmodule

// File: tb/tb_seq_detect_n.sv
// Bench for seq_detect_n: directed scenarios plus randomized traffic against a
// bit-queue reference model; two instances share inputs (CNT_W=8 and CNT_W=2).
module tb_seq_detect_n;

    localparam int PAT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             din = 1'b0;
    logic             overlap = 1'b0;
    logic             pat_load = 1'b0;
    logic [PAT_W-1:0] pat_in = '0;
    logic             clr_cnt = 1'b0;

    logic             match_a, match_b;
    logic [7:0]       cnt_a;
    logic [1:0]       cnt_b;
    logic             sat_a, sat_b;
    logic [2:0]       fill_a, fill_b;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [PAT_W-1:0] m_pat;
    bit               seg[$];
    int               m_raw;
    bit               m_match;

    always #5 clk = ~clk;

    seq_detect_n #(.PAT_W(4), .CNT_W(8), .PAT_INIT(4'b1011)) dut_a (
        .clk(clk), .rst(rst), .en(en), .din(din), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .clr_cnt(clr_cnt),
        .match(match_a), .match_cnt(cnt_a), .cnt_sat(sat_a), .fill(fill_a)
    );

    seq_detect_n #(.PAT_W(4), .CNT_W(2), .PAT_INIT(4'b1011)) dut_b (
        .clk(clk), .rst(rst), .en(en), .din(din), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .clr_cnt(clr_cnt),
        .match(match_b), .match_cnt(cnt_b), .cnt_sat(sat_b), .fill(fill_b)
    );

    function automatic int exp_cnt(input int maxv);
        return (m_raw > maxv) ? maxv : m_raw;
    endfunction

    function automatic int exp_fill();
        return (seg.size() > PAT_W) ? PAT_W : seg.size();
    endfunction

    // Model: sampled bits since the last restart; match when the newest PAT_W equal the pattern.
    task automatic model_edge();
        logic [PAT_W-1:0] tail;
        bit hit;
        if (rst) begin
            m_pat = 4'b1011;
            seg.delete();
            m_raw = 0;
            m_match = 0;
        end else begin
            if (clr_cnt) m_raw = 0;
            if (pat_load) begin
                m_pat = pat_in;
                seg.delete();
                m_match = 0;
            end else if (en) begin
                seg.push_back(din);
                hit = 0;
                if (seg.size() >= PAT_W) begin
                    tail = '0;
                    for (int i = seg.size() - PAT_W; i < seg.size(); i++)
                        tail = {tail[PAT_W-2:0], seg[i]};
                    hit = (tail == m_pat);
                end
                if (hit) begin
                    m_raw++;
                    if (!overlap) seg.delete();
                end
                while (seg.size() > PAT_W) void'(seg.pop_front());
                m_match = hit;
            end else begin
                m_match = 0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input bit e, input bit d);
        en = e; din = d; pat_load = 0; clr_cnt = 0; rst = 0;
        cycle();
    endtask

    task automatic do_reset();
        rst = 1; en = 0; pat_load = 0; clr_cnt = 0;
        cycle();
        cycle();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; en = 1; din = 1; pat_load = 1; pat_in = 4'b0000; clr_cnt = 0;
        cycle();
        cycle();
        rst = 0; en = 0; pat_load = 0;
        checks++; if (match_a !== 1'b0) begin errors++; $display("FAIL reset_match: got %0b want 0", match_a); end
        checks++; if (cnt_a !== 8'd0)   begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt_a); end
        checks++; if (sat_a !== 1'b0)   begin errors++; $display("FAIL reset_sat: got %0b want 0", sat_a); end
        checks++; if (fill_a !== 3'd0)  begin errors++; $display("FAIL reset_fill: got %0d want 0", fill_a); end
        checks++; if (cnt_b !== 2'd0 || sat_b !== 1'b0) begin errors++; $display("FAIL reset_cnt2: got %0d/%0b want 0/0", cnt_b, sat_b); end
        // Pattern must be back to 1011 even though pat_load was high during reset.
        overlap = 1;
        drive(1, 1); drive(1, 0); drive(1, 1); drive(1, 1);
        checks++; if (match_a !== 1'b1) begin errors++; $display("FAIL reset_pattern: got %0b want 1", match_a); end
    endtask

    task automatic run_stream(input bit ov, output int pulses);
        bit stream[7] = '{1, 0, 1, 1, 0, 1, 1};
        bit want[7];
        pulses = 0;
        want = ov ? '{0, 0, 0, 1, 0, 0, 1} : '{0, 0, 0, 1, 0, 0, 0};
        do_reset();
        overlap = ov;
        for (int i = 0; i < 7; i++) begin
            drive(1, stream[i]);
            if (match_a) pulses++;
            checks++;
            if (match_a !== want[i]) begin errors++; $display("FAIL stream_ov%0d_bit%0d: got %0b want %0b", ov, i + 1, match_a, want[i]); end
        end
    endtask

    task automatic test_overlap();
        int p;
        run_stream(1, p);
        checks++; if (cnt_a !== 8'd2) begin errors++; $display("FAIL overlap_cnt: got %0d want 2", cnt_a); end
        checks++; if (fill_a !== 3'd4) begin errors++; $display("FAIL overlap_fill: got %0d want 4", fill_a); end
    endtask

    task automatic test_non_overlap();
        int p;
        run_stream(0, p);
        checks++; if (p != 1)          begin errors++; $display("FAIL nonov_pulses: got %0d want 1", p); end
        checks++; if (fill_a !== 3'd3) begin errors++; $display("FAIL nonov_fill: got %0d want 3", fill_a); end
        checks++; if (cnt_a !== 8'd1)  begin errors++; $display("FAIL nonov_cnt: got %0d want 1", cnt_a); end
    endtask

    task automatic test_enable_gap();
        int p = 0;
        do_reset();
        overlap = 1;
        drive(1, 1); drive(1, 0); drive(1, 1);
        for (int i = 0; i < 3; i++) begin
            drive(0, i[0]);
            if (match_a) p++;
        end
        checks++; if (fill_a !== 3'd3) begin errors++; $display("FAIL gap_fill: got %0d want 3", fill_a); end
        drive(1, 1);
        if (match_a) p++;
        checks++; if (match_a !== 1'b1) begin errors++; $display("FAIL gap_final_match: got %0b want 1", match_a); end
        drive(0, 1);
        if (match_a) p++;
        checks++; if (p != 1) begin errors++; $display("FAIL gap_pulses: got %0d want 1", p); end
    endtask

    task automatic test_pat_load();
        bit s[4] = '{0, 1, 1, 0};
        int p = 0;
        do_reset();
        overlap = 1;
        drive(1, 1); drive(1, 0); drive(1, 1);
        en = 1; din = 1; pat_load = 1; pat_in = 4'b0110;
        cycle();
        pat_load = 0;
        checks++; if (fill_a !== 3'd0 || match_a !== 1'b0) begin errors++; $display("FAIL load_edge: got fill=%0d match=%0b want 0/0", fill_a, match_a); end
        for (int i = 0; i < 4; i++) begin
            drive(1, s[i]);
            if (match_a) p++;
        end
        checks++; if (p != 1 || match_a !== 1'b1) begin errors++; $display("FAIL load_match: got pulses=%0d last=%0b want 1/1", p, match_a); end
    endtask

    task automatic test_saturation();
        bit s[16] = '{1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
        int p = 0;
        do_reset();
        overlap = 1;
        for (int i = 0; i < 16; i++) begin
            drive(1, s[i]);
            if (match_b) p++;
        end
        checks++; if (p != 5)          begin errors++; $display("FAIL sat_pulses: got %0d want 5", p); end
        checks++; if (cnt_b !== 2'd3)  begin errors++; $display("FAIL sat_cnt: got %0d want 3", cnt_b); end
        checks++; if (sat_b !== 1'b1)  begin errors++; $display("FAIL sat_flag: got %0b want 1", sat_b); end
        checks++; if (cnt_a !== 8'd5 || sat_a !== 1'b0) begin errors++; $display("FAIL sat_wide_cnt: got %0d/%0b want 5/0", cnt_a, sat_a); end
        en = 0; clr_cnt = 1;
        cycle();
        clr_cnt = 0;
        checks++; if (cnt_b !== 2'd0 || sat_b !== 1'b0) begin errors++; $display("FAIL sat_clear: got %0d/%0b want 0/0", cnt_b, sat_b); end
    endtask

    task automatic test_clr_with_match();
        do_reset();
        overlap = 1;
        drive(1, 1); drive(1, 0); drive(1, 1); drive(1, 1);
        drive(1, 0); drive(1, 1);
        en = 1; din = 1; clr_cnt = 1;
        cycle();
        clr_cnt = 0;
        checks++; if (match_a !== 1'b1 || cnt_a !== 8'd1) begin errors++; $display("FAIL clr_same_edge: got match=%0b cnt=%0d want 1/1", match_a, cnt_a); end
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            en       = ($urandom_range(0, 9) < 8);
            din      = $urandom_range(0, 1);
            overlap  = ($urandom_range(0, 29) == 0) ? ~overlap : overlap;
            pat_load = ($urandom_range(0, 99) == 0);
            pat_in   = 4'($urandom_range(0, 15));
            clr_cnt  = ($urandom_range(0, 149) == 0);
            cycle();
            checks++;
            if (match_a !== m_match || match_b !== m_match || fill_a !== 3'(exp_fill()) || fill_b !== 3'(exp_fill())
                || cnt_a !== 8'(exp_cnt(255)) || cnt_b !== 2'(exp_cnt(3))
                || sat_a !== (exp_cnt(255) == 255) || sat_b !== (exp_cnt(3) == 3)) begin
                errors++;
                if (bad < 10)
                    $display("FAIL random_cyc%0d: got match=%0b fill=%0d cnt=%0d/%0d sat=%0b/%0b want match=%0b fill=%0d cnt=%0d/%0d",
                             i, match_a, fill_a, cnt_a, cnt_b, sat_a, sat_b, m_match, exp_fill(), exp_cnt(255), exp_cnt(3));
                bad++;
            end
        end
        rst = 0; pat_load = 0; clr_cnt = 0; en = 0;
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_non_overlap();
        test_enable_gap();
        test_pat_load();
        test_saturation();
        test_clr_with_match();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_detect_n.md
SEQ_DETECT_N -- requirements
Module: seq_detect_n

Interface
REQ-001 SHALL have parameter PAT_W, default 4, pattern length in bits, legal range 2..8.
REQ-002 SHALL have parameter CNT_W, default 8, match-counter width, legal range 2..16.
REQ-003 SHALL have parameter PAT_INIT, default 4'b1011 (PAT_W bits), pattern value loaded at reset.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port en, input, 1, din is sampled on this edge when high.
REQ-007 SHALL have port din, input, 1, serial data bit.
REQ-008 SHALL have port overlap, input, 1, 1 = overlapping matches allowed, 0 = non-overlapping.
REQ-009 SHALL have port pat_load, input, 1, load pat_in as the new pattern.
REQ-010 SHALL have port pat_in, input, PAT_W, new pattern, MSB = first bit received.
REQ-011 SHALL have port clr_cnt, input, 1, clear match counter and saturation flag.
REQ-012 SHALL have port match, output, 1, one-cycle registered match pulse.
REQ-013 SHALL have port match_cnt, output, CNT_W, saturating count of matches.
REQ-014 SHALL have port cnt_sat, output, 1, high while match_cnt equals 2^CNT_W-1.
REQ-015 SHALL have port fill, output, clog2(PAT_W+1), number of valid history bits (FSM state).

Function
REQ-016 SHALL hold the pattern register, a PAT_W-bit history shift register and a fill state 0..PAT_W.
REQ-017 SHALL, on an edge with en=1 and pat_load=0, shift din into the history LSB and advance fill by 1, saturating at PAT_W.
REQ-018 SHALL detect a match when the post-shift fill equals PAT_W and the post-shift history equals the pattern.
REQ-019 SHALL drive match high for exactly the one cycle after the edge that sampled the completing bit, so latency is 1 cycle.
REQ-020 SHALL, when overlap=1 and a match occurs, keep history and hold fill at PAT_W so the next bit can complete another match.
REQ-021 SHALL, when overlap=0 and a match occurs, reset fill to 0 on that same edge so the next match needs PAT_W fresh bits.
REQ-022 SHALL, on an edge with en=0, leave history, fill and pattern unchanged and drive match low.
REQ-023 SHALL, on pat_load=1, load pat_in, clear history and fill to 0, and drive match low; pat_load takes priority over en and the din on that edge is discarded.
REQ-024 SHALL increment match_cnt by 1 on each match and hold it at 2^CNT_W-1 thereafter; match pulses continue while saturated.
REQ-025 SHALL apply clr_cnt before the increment, so clr_cnt and a match on the same edge give match_cnt=1.
REQ-026 SHALL sample overlap on every edge; a change takes effect from the next sampled bit.

Reset
REQ-027 SHALL, when rst=1 at a clock edge, set pattern=PAT_INIT, history=0, fill=0, match=0, match_cnt=0, cnt_sat=0; rst overrides every other input, including mid-stream.
REQ-028 SHALL produce no match on the first PAT_W-1 sampled bits after reset, regardless of history content.

Verification
REQ-029 SHALL pass: rst high 2 cycles -> match=0, match_cnt=0, cnt_sat=0, fill=0.
REQ-030 SHALL pass: PAT_W=4, pattern 1011, overlap=1, en=1, din stream 1,0,1,1,0,1,1 -> match pulses after bits 4 and 7, match_cnt=2.
REQ-031 SHALL pass: same stream with overlap=0 -> single pulse after bit 4, fill=3 at end, match_cnt=1.
REQ-032 SHALL pass: stream 1,0,1 with en=0 for 3 cycles (din toggling) and then bit 1 -> exactly one match pulse after the final bit.
REQ-033 SHALL pass: after bits 1,0,1, pat_load=1 with pat_in=0110 and en=1 on the same edge -> fill=0, no match; the stream 0,1,1,0 then gives 1 match.
REQ-034 SHALL pass: CNT_W=2, 5 overlapping matches -> 5 match pulses, match_cnt=3, cnt_sat=1; clr_cnt on the next edge -> match_cnt=0, cnt_sat=0.
